// File: rtl/uart_line_pkg.sv
// Shared types and ASCII constants for the line-buffered UART upper-casing stage.
package uart_line_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    EMIT_CR,
    EMIT_LF
  } state_t;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] DEL = 8'h7F;

  // Only 'a'..'z' move; neighbours such as '`' and '{' pass untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) ? (c - 8'h20) : c;
  endfunction

endpackage

// File: rtl/uart_line_upper.sv
// Collects an edited input line, then replays it (optionally upper-cased) followed by CR LF.
module uart_line_upper
  import uart_line_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter bit UPPER   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       busy,
  output logic       ovf
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       line_mem_q [MAX_LEN];
  logic             wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [IDX_W-1:0] rd_next;
  logic             s_fire;
  logic             m_fire;

  function automatic logic [7:0] out_byte(input logic [7:0] b);
    return UPPER ? to_upper(b) : b;
  endfunction

  assign s_fire  = s_valid && s_ready_q;
  assign m_fire  = m_valid_q && m_ready;
  assign rd_next = rd_idx_q + IDX_ONE;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_idx_d  = rd_idx_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    busy_d    = busy_q;
    ovf_d     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = len_q[ADDR_W-1:0];

    case (state_q)
      COLLECT: begin
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (s_fire) begin
          if (s_data == CR) begin
            // Output byte is registered here so it is valid the cycle after CR.
            rd_idx_d  = '0;
            s_ready_d = 1'b0;
            m_valid_d = 1'b1;
            busy_d    = 1'b1;
            if (len_q != '0) begin
              state_d  = EMIT;
              m_data_d = out_byte(line_mem_q[0]);
            end else begin
              state_d  = EMIT_CR;
              m_data_d = CR;
            end
          end else if ((s_data == BS) || (s_data == DEL)) begin
            if (len_q != '0) len_d = len_q - IDX_ONE;
          end else if (s_data != LF) begin
            if (len_q < MAX_IDX) begin
              wr_en = 1'b1;
              len_d = len_q + IDX_ONE;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      EMIT: begin
        if (m_fire) begin
          if (rd_next == len_q) begin
            state_d  = EMIT_CR;
            m_data_d = CR;
          end else begin
            rd_idx_d = rd_next;
            m_data_d = out_byte(line_mem_q[rd_next[ADDR_W-1:0]]);
          end
        end
      end
      EMIT_CR: begin
        if (m_fire) begin
          state_d  = EMIT_LF;
          m_data_d = LF;
        end
      end
      EMIT_LF: begin
        if (m_fire) begin
          state_d   = COLLECT;
          len_d     = '0;
          m_valid_d = 1'b0;
          m_data_d  = '0;
          busy_d    = 1'b0;
          s_ready_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      len_q     <= '0;
      rd_idx_q  <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_idx_q  <= rd_idx_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  // Line storage carries no reset; len_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) line_mem_q[wr_addr] <= s_data;
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_line_upper.sv
// Directed bench for uart_line_upper: three instances cover default, short-buffer and pass-through builds.
module tb_uart_line_upper;

  localparam logic [7:0] K_CR  = 8'h0D;
  localparam logic [7:0] K_LF  = 8'h0A;
  localparam logic [7:0] K_BS  = 8'h08;
  localparam logic [7:0] K_DEL = 8'h7F;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst;
  logic       s_valid [3];
  logic [7:0] s_data  [3];
  logic       s_ready [3];
  logic       m_valid [3];
  logic [7:0] m_data  [3];
  logic       m_ready [3];
  logic       busy    [3];
  logic       ovf     [3];

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic ovf_at, ovf_after, mv_before, mv_at;

  uart_line_upper #(.MAX_LEN(64), .UPPER(1'b1)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
    .m_valid(m_valid[0]), .m_data(m_data[0]), .m_ready(m_ready[0]), .busy(busy[0]), .ovf(ovf[0]));

  uart_line_upper #(.MAX_LEN(4), .UPPER(1'b1)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
    .m_valid(m_valid[1]), .m_data(m_data[1]), .m_ready(m_ready[1]), .busy(busy[1]), .ovf(ovf[1]));

  uart_line_upper #(.MAX_LEN(64), .UPPER(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_data(s_data[2]), .s_ready(s_ready[2]),
    .m_valid(m_valid[2]), .m_data(m_data[2]), .m_ready(m_ready[2]), .busy(busy[2]), .ovf(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one byte, waits for acceptance, then idles one cycle; samples ovf/m_valid around it.
  task automatic send(input int i, input logic [7:0] b);
    int n;
    n = 0;
    s_valid[i] = 1'b1;
    s_data[i]  = b;
    while (!s_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    mv_before = m_valid[i];
    @(negedge clk);
    ovf_at     = ovf[i];
    mv_at      = m_valid[i];
    s_valid[i] = 1'b0;
    @(negedge clk);
    ovf_after = ovf[i];
  endtask

  task automatic send_s(input int i, input string s);
    for (int k = 0; k < s.len(); k++) send(i, s[k]);
  endtask

  function automatic bq_t mkline(input string s);
    bq_t q;
    q = {};
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    q.push_back(K_CR);
    q.push_back(K_LF);
    return q;
  endfunction

  // Drains one line; with stall>0 holds m_ready low that many cycles after each accepted byte.
  task automatic recv(input int i, input int stall, output bq_t got, output int gaps);
    int remain;
    int n;
    bit took;
    bit done;
    logic [7:0] held;
    got = {};
    gaps = 0; remain = 0; n = 0; took = 0; done = 0; held = '0;
    m_ready[i] = 1'b1;
    while (!done && n < 400) begin
      if (took && stall > 0) begin
        m_ready[i] = 1'b0;
        remain = stall;
        held = m_data[i];
      end else if (remain > 0) begin
        chk("stall_hold", m_data[i], held);
        remain--;
        if (remain == 0) m_ready[i] = 1'b1;
      end
      took = 0;
      if (m_valid[i]) begin
        chk("emit_s_ready", s_ready[i], 32'd0);
        chk("emit_busy", busy[i], 32'd1);
        if (m_ready[i]) begin
          got.push_back(m_data[i]);
          took = 1;
          if (m_data[i] == K_LF) done = 1;
        end
      end else begin
        gaps++;
      end
      @(negedge clk);
      n++;
    end
    if (!done) chk("recv_timeout", 32'd0, 32'd1);
    m_ready[i] = 1'b0;
  endtask

  task automatic cmp_line(input string tag, input bq_t got, input bq_t exp);
    logic [31:0] o;
    chk({tag, "_len"}, got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < got.size()) o = {24'h0, got[k]};
      else o = '1;
      chk($sformatf("%s_b%0d", tag, k), o, {24'h0, exp[k]});
    end
  endtask

  initial begin
    bq_t got;
    bq_t exp;
    int  gaps;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      m_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready[0], 32'd0);
    chk("rst_m_valid", m_valid[0], 32'd0);
    chk("rst_m_data", m_data[0], 32'd0);
    chk("rst_busy", busy[0], 32'd0);
    chk("rst_ovf", ovf[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready_rise", s_ready[0], 32'd1);

    // 1: case mapping at range edges, latency, back-to-back output
    send_s(0, "a1!z{");
    send(0, 8'h60);
    send(0, K_CR);
    chk("t1_mvalid_before_cr", mv_before, 32'd0);
    chk("t1_mvalid_after_cr", mv_at, 32'd1);
    recv(0, 0, got, gaps);
    exp = {8'h41, 8'h31, 8'h21, 8'h5A, 8'h7B, 8'h60, K_CR, K_LF};
    cmp_line("t1", got, exp);
    chk("t1_gaps", gaps, 32'd0);

    // 2: editing, including BS/DEL on an empty buffer
    send_s(0, "ab");
    send(0, K_BS);
    send_s(0, "c");
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t2a", got, mkline("AC"));
    send(0, K_BS);
    send(0, K_DEL);
    send_s(0, "x");
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t2b", got, mkline("X"));

    // 3: empty line, CRLF input
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t3a", got, mkline(""));
    send_s(0, "q");
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t3b", got, mkline("Q"));
    send(0, K_LF);
    m_ready[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t3_lf_silent", m_valid[0], 32'd0);
      @(negedge clk);
    end
    m_ready[0] = 1'b0;
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t3c", got, mkline(""));

    // 4: overflow on a 4-deep buffer, then pass-through build
    for (int k = 0; k < 6; k++) begin
      send(1, 8'h61 + 8'(k));
      chk($sformatf("t4_ovf_at_%0d", k), ovf_at, (k >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("t4_ovf_after_%0d", k), ovf_after, 32'd0);
    end
    send(1, K_CR);
    recv(1, 0, got, gaps);
    cmp_line("t4a", got, mkline("ABCD"));
    send_s(2, "abc");
    send(2, K_CR);
    recv(2, 0, got, gaps);
    cmp_line("t4b", got, mkline("abc"));

    // 5: backpressure, with a byte waiting upstream during emit
    send_s(0, "hello");
    send(0, K_CR);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h79;
    recv(0, 5, got, gaps);
    cmp_line("t5a", got, mkline("HELLO"));
    chk("t5_s_ready_after_lf", s_ready[0], 32'd1);
    @(negedge clk);
    s_valid[0] = 1'b0;
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t5b", got, mkline("Y"));

    // 6: reset in the middle of an emit
    send_s(0, "abcd");
    send(0, K_CR);
    m_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_third_byte", m_data[0], 32'h43);
    m_ready[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_m_valid", m_valid[0], 32'd0);
    chk("t6_busy", busy[0], 32'd0);
    chk("t6_s_ready_low", s_ready[0], 32'd0);
    @(negedge clk);
    chk("t6_s_ready_high", s_ready[0], 32'd1);
    send_s(0, "z");
    send(0, K_CR);
    recv(0, 0, got, gaps);
    cmp_line("t6", got, mkline("Z"));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_line_upper.md
Name: uart_line_upper

Overview:
Line-buffered stage that sits between the UART receiver byte stream and the UART transmitter byte stream in the demo SoC.
- Collects received characters into a line buffer and applies backspace editing.
- On carriage return, emits the whole line in one burst, optionally uppercased, terminated by CR LF.
- Replaces per-character echo with whole-line processing. Both sides use a valid/ready byte stream.

Parameters:
MAX_LEN, 64, line buffer depth in bytes (2..256); index width = $clog2(MAX_LEN+1)
UPPER, 1, 1 = convert 'a'..'z' to 'A'..'Z' on output; 0 = pass bytes through unchanged

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
s_valid  input  1  received byte valid (from UART RX)
s_data  input  8  received byte
s_ready  output  1  block accepts s_data this cycle
m_valid  output  1  output byte valid (to UART TX)
m_data  output  8  output byte
m_ready  input  1  UART TX accepts m_data
busy  output  1  high while a line is being emitted
ovf  output  1  one-cycle pulse per received byte dropped because the buffer is full

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, busy=0, ovf=0, len=0, state=COLLECT. s_ready rises the first cycle after rst deasserts.
- Transfer rule: a transfer occurs when valid && ready in the same cycle.
- Source rules: once m_valid is asserted, m_valid and m_data hold stable until accepted.
- Sink rules: s_ready never depends combinationally on s_valid.

FSM states: COLLECT, EMIT, EMIT_CR, EMIT_LF.

COLLECT:
- s_ready=1, m_valid=0, busy=0.
- Printable or other byte, len<MAX_LEN: buf[len]<=byte; len++.
- Byte with len==MAX_LEN: dropped, ovf=1 next cycle, len unchanged.
- BS (0x08) or DEL (0x7F): len-- if len>0; ignored when len==0.
- LF (0x0A): ignored and not stored. This lets CRLF input work.
- CR (0x0D): not stored. rd_idx<=0; next state is EMIT if len>0, else EMIT_CR.

EMIT:
- s_ready=0, busy=1, m_valid=1.
- m_data = UPPER ? upper(buf[rd_idx]) : buf[rd_idx].
- On transfer: rd_idx++. When rd_idx==len-1 is transferred, go to EMIT_CR.

EMIT_CR:
- m_valid=1, m_data=0x0D, busy=1.
- On transfer, go to EMIT_LF.

EMIT_LF:
- m_valid=1, m_data=0x0A, busy=1.
- On transfer: len<=0, go to COLLECT. s_ready is 1 the following cycle.

Latency and throughput:
- First output byte is valid the cycle after the CR is accepted.
- With m_ready held high, one byte per cycle: len+2 cycles per line.

Uppercase rule:
- Only 0x61..0x7A are mapped, by subtracting 0x20.
- 0x60 '`' and 0x7B '{' pass unchanged.
- Buffer contents are never modified; conversion happens on output only.

Other rules:
- Input arriving during EMIT*: held off by s_ready=0. No bytes are lost upstream.
- Reset mid-line or mid-emit: everything returns to reset values next cycle. The partial line is discarded.

Decomposition:
- Package uart_line_pkg contains:
  - state_t enum (COLLECT, EMIT, EMIT_CR, EMIT_LF)
  - ASCII constants CR=8'h0D, LF=8'h0A, BS=8'h08, DEL=8'h7F
  - function to_upper(input [7:0]) returning [7:0]
- Buffer is an inferred single-write, single-read memory in this module. No sub-module; the buffer is too small to warrant one.

Test Plan:
1. Send "a1!z{`" then CR, m_ready=1 → m_data sequence 0x41 '1' '!' 0x5A '{' '`' 0x0D 0x0A. First m_valid is exactly 1 cycle after CR is accepted; 8 consecutive transfer cycles.
2. Send "ab", BS, "c", CR; then separately BS, BS, "x", CR → outputs "AC\r\n" then "X\r\n". A BS on an empty buffer changes nothing.
3. Send CR alone, and "q" followed by CR LF → outputs "\r\n" and "Q\r\n". The LF produces no extra output.
4. With MAX_LEN=4, send "abcdef" then CR → output "ABCD\r\n"; ovf pulses exactly twice, on the cycles after 'e' and 'f' are accepted. With UPPER=0, "abc" then CR → "abc\r\n".
5. Backpressure: "hello" then CR with m_ready low 5 cycles after each acceptance → m_data stable while stalled, output "HELLO\r\n" with no loss. s_ready=0 and busy=1 throughout; a byte offered during emit is accepted only after the LF.
6. Reset mid-emit: assert rst for 1 cycle after 2 bytes of "abcd"+CR are emitted → next cycle m_valid=0, busy=0, then s_ready=1. Subsequent "z" then CR yields exactly "Z\r\n".
